// File: rtl/operand_loader_pkg.sv
// Shared constants and enums for the operand loader and its neighbours.
// Holds the operand width, the loader FSM state encoding and the opcode set.
// No logic; imported by operand_loader and any stage that decodes op_out.
package Pkg_Global;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    LOAD_X = 2'd0,
    LOAD_Y = 2'd1,
    ARMED  = 2'd2,
    RUN    = 2'd3
  } loader_state_t;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_SQRT = 2'b10,
    OP_RSVD = 2'b11
  } opcode_t;

endpackage

// File: rtl/operand_loader_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for a slow asynchronous level.
// Latency: d sampled high at edge k gives pulse high during the cycle after edge k+1.
// No backpressure; one pulse per rising edge, a held level never retriggers.
// Ports: clk, rst (async active-low), d (async level in), pulse (one-cycle out).
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic       s1, s2, s3;
  logic [1:0] fill;      // marks when s2 holds a real sample rather than reset zero
  logic       seen_low;  // input observed low since reset; blocks an edge from a level held through reset

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      fill     <= 2'b00;
      seen_low <= 1'b0;
    end else begin
      s1       <= d;
      s2       <= s1;
      s3       <= s2;
      fill     <= {fill[0], 1'b1};
      seen_low <= seen_low | (fill[1] & ~s2);
    end
  end

  assign pulse = s2 & ~s3 & seen_low;

endmodule

// File: rtl/operand_loader.sv
// Captures operand X, then operand Y with its opcode, from a button-style load
// input, then issues a one-cycle start and waits for done from the control stage.
// Latency: load first sampled at edge k is visible on outputs after edge k+2.
// Backpressure: loads arriving in ARMED/RUN are dropped and flagged on sticky ovr.
// Ports: clk, rst (async active-low), load, data_in, op, done in;
//        x_out, y_out, op_out, loaded_x, loaded_y, start, err, ovr out (all registered).
module operand_loader
  import Pkg_Global::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] data_in,
  input  logic [1:0]    op,
  input  logic          done,
  output logic [DW-1:0] x_out,
  output logic [DW-1:0] y_out,
  output logic [1:0]    op_out,
  output logic          loaded_x,
  output logic          loaded_y,
  output logic          start,
  output logic          err,
  output logic          ovr
);

  logic          load_pulse;
  loader_state_t state, state_nxt;

  logic cap_x, cap_y, rej_y, busy_load, release_ops;

  sync_edge u_load_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (load),
    .pulse (load_pulse)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD_X;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_X: if (load_pulse) state_nxt = LOAD_Y;
      LOAD_Y: if (load_pulse && (op != OP_RSVD)) state_nxt = ARMED;
      ARMED:  state_nxt = RUN;
      RUN:    if (done) state_nxt = LOAD_X;
      default: state_nxt = LOAD_X;
    endcase
  end

  always_comb begin
    cap_x       = (state == LOAD_X) && load_pulse;
    cap_y       = (state == LOAD_Y) && load_pulse && (op != OP_RSVD);
    rej_y       = (state == LOAD_Y) && load_pulse && (op == OP_RSVD);
    // Covers the done+load collision in RUN too: done wins, the load is only flagged.
    busy_load   = ((state == ARMED) || (state == RUN)) && load_pulse;
    release_ops = (state == RUN) && done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_out    <= '0;
      y_out    <= '0;
      op_out   <= 2'b00;
      loaded_x <= 1'b0;
      loaded_y <= 1'b0;
      start    <= 1'b0;
      err      <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      // start tracks the ARMED state exactly, one cycle per pass through the FSM.
      start <= (state_nxt == ARMED);
      err   <= rej_y;

      if (cap_x) begin
        x_out    <= data_in;
        loaded_x <= 1'b1;
        ovr      <= 1'b0;
      end else if (busy_load) begin
        ovr <= 1'b1;
      end

      if (cap_y) begin
        y_out    <= data_in;
        op_out   <= op;
        loaded_y <= 1'b1;
      end

      // Operand values stay on the outputs after completion; only the valid flags drop.
      if (release_ops) begin
        loaded_x <= 1'b0;
        loaded_y <= 1'b0;
      end
    end
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter DW, default 16 (DATA_WIDTH from Pkg_Global), operand width in bits.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 load  input  1  asynchronous operator load request (push button / switch level).
REQ-005 data_in  input  DW  operand value presented with load.
REQ-006 op  input  2  operation code; 00 mul, 01 div, 10 sqrt, 11 reserved.
REQ-007 done  input  1  one-cycle pulse from the downstream control stage when the operation completes.
REQ-008 x_out  output  DW  captured operand X.
REQ-009 y_out  output  DW  captured operand Y.
REQ-010 op_out  output  2  opcode captured together with Y.
REQ-011 loaded_x  output  1  high while X holds a valid capture.
REQ-012 loaded_y  output  1  high while Y holds a valid capture.
REQ-013 start  output  1  one-cycle request to the downstream control stage.
REQ-014 err  output  1  one-cycle pulse on a rejected reserved opcode.
REQ-015 ovr  output  1  sticky flag: a load edge was ignored while busy.

Function
REQ-016 load SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal SHALL produce exactly one internal load_pulse; a held level SHALL NOT retrigger.
REQ-017 Latency: if load is first sampled high at edge k, the capture SHALL be visible on outputs after edge k+2.
REQ-018 FSM states: LOAD_X, LOAD_Y, ARMED, RUN; encoding from the shared package.
REQ-019 LOAD_X: on load_pulse, x_out <= data_in, loaded_x <= 1, ovr <= 0, next LOAD_Y; otherwise hold.
REQ-020 LOAD_Y: on load_pulse with op != 11, y_out <= data_in, op_out <= op, loaded_y <= 1, next ARMED.
REQ-021 LOAD_Y: on load_pulse with op == 11, SHALL not capture, SHALL pulse err for one cycle, SHALL remain in LOAD_Y.
REQ-022 ARMED: start SHALL be high for exactly the one cycle spent in ARMED; next state RUN unconditionally.
REQ-023 RUN: on done, loaded_x <= 0, loaded_y <= 0, next LOAD_X; x_out, y_out, op_out SHALL hold their values.
REQ-024 load_pulse in ARMED or RUN SHALL be ignored and SHALL set ovr.
REQ-025 done and load_pulse in the same RUN cycle: done SHALL take effect, the load SHALL be dropped, and ovr SHALL be set.
REQ-026 done outside RUN SHALL be ignored.
REQ-027 start SHALL never assert twice without an intervening done.

Reset
REQ-028 On rst low, state SHALL be LOAD_X; x_out, y_out, op_out, loaded_x, loaded_y, start, err, ovr and all synchronizer/edge flops SHALL be 0.
REQ-029 Reset mid-operation, including in RUN, SHALL discard captured operands; an edge on load held high through reset release SHALL NOT generate a pulse until load is released and pressed again.

Structure
REQ-030 Pkg_Global SHALL hold the DATA_WIDTH constant, the loader state enum and the opcode enum, including the reserved code.
REQ-031 Synchronizer and rising-edge detection SHALL be the sub-module sync_edge (inputs clk, rst, d; output pulse), reusable for the start button.
REQ-032 Outputs SHALL be registered; start SHALL be decoded from state == ARMED.

Verification
REQ-033 Reset, then load pulses with data_in=0x0007 and then 0x0003, op=00 -> x_out=0x0007, y_out=0x0003, op_out=00, start high for exactly 1 cycle, loaded_x=loaded_y=1.
REQ-034 Hold load high for 50 cycles in LOAD_X with data_in=0x00AA -> exactly one capture, state LOAD_Y, loaded_y=0.
REQ-035 In LOAD_Y, pulse load with op=11 and data_in=0x0005 -> err for 1 cycle, y_out unchanged at 0, loaded_y=0; retry with op=01 -> capture 0x0005, start pulse.
REQ-036 In RUN, pulse load with data_in=0xFFFF -> ovr=1, x_out unchanged; then done -> LOAD_X, loaded_x=0, ovr=1 until the next X capture clears it.
REQ-037 Assert done in the same cycle as load_pulse in RUN -> state LOAD_X, no capture, ovr=1.
REQ-038 Drop rst in RUN -> all outputs 0 immediately; load held high across reset release -> no capture until a new rising edge.
